menu_controller: RTL and testbench
==================================

# menu_controller

Sequencer and arbiter for the title-menu label ROMs (PLAY and EXIT, each 20×7 tiles of 8×8 pixels, 4-bit colour index, 4'd8 = transparent). It sits between the VGA counter and the label ROMs, and has three jobs:
- decode which label window the beam is in and feed that ROM its window-local coordinates;
- merge the two ROM outputs into one registered pixel stream, with a blinking highlight on the selected entry;
- run the menu selection FSM that launches or exits the game.

## Interface
Parameters:
- PLAY_X, 240, left edge of the PLAY window (pixels)
- PLAY_Y, 200, top edge of the PLAY window
- EXIT_X, 240, left edge of the EXIT window
- EXIT_Y, 280, top edge of the EXIT window
- LBL_W, 160, window width (20 tiles × 8)
- LBL_H, 56, window height (7 tiles × 8)
- BLINK_FRAMES, 30, frames per blink half-period
- HILITE, 4'd15, colour substituted for opaque pixels of the selected label while blink is on

Ports:
- CLK  in  1  pixel clock; hc advances once per cycle
- RST  in  1  reset, synchronous, active-high
- hc  in  10  VGA horizontal count
- vc  in  10  VGA vertical count
- btn_up  in  1  level; synchronised and debounced upstream
- btn_down  in  1  level; synchronised and debounced upstream
- btn_sel  in  1  level; synchronised and debounced upstream
- game_over  in  1  one-cycle pulse from the game core
- play_pixel  in  4  PLAY ROM output (combinational from play_in_pixel, lbl_hc, lbl_vc)
- exit_pixel  in  4  EXIT ROM output (combinational from exit_in_pixel, lbl_hc, lbl_vc)
- play_in_pixel  out  1  beam inside the PLAY window (registered)
- exit_in_pixel  out  1  beam inside the EXIT window (registered)
- lbl_hc  out  10  window-local x, shared by both ROMs (registered)
- lbl_vc  out  10  window-local y, shared by both ROMs (registered)
- pixel  out  4  composed menu pixel (registered)
- start_game  out  1  one-cycle pulse
- exit_req  out  1  one-cycle pulse
- menu_active  out  1  high while the menu is displayed

## Operation
- Edge detect: one register per button; an edge is current=1 and previous=0. Edges are only acted on in MENU.
- FSM states: MENU, LAUNCH, GAME.
  - MENU:
    - up edge alone sets sel=0; down edge alone sets sel=1. Both saturate, so there is no wrap.
    - up and down edges in the same cycle are both ignored.
    - A sel edge goes to LAUNCH, using the current sel. It wins over a simultaneous up or down edge.
  - LAUNCH lasts one cycle:
    - sel=0 pulses start_game and goes to GAME.
    - sel=1 pulses exit_req and goes to MENU with sel=0.
  - GAME: menu_active=0 and the windows are never reported as hit. A game_over pulse goes to MENU with sel=0.
  - game_over is ignored outside GAME.
- Window decode (stage 1):
  - Inside PLAY when PLAY_X ≤ hc < PLAY_X+LBL_W and PLAY_Y ≤ vc < PLAY_Y+LBL_H; EXIT is decoded the same way.
  - Use 11-bit compares so the sums never overflow.
  - If the windows overlap, PLAY has priority and only one of play_in_pixel/exit_in_pixel is ever high.
  - lbl_hc = hc−X and lbl_vc = vc−Y of the hit window; both are 0 when no window is hit.
  - In any state other than MENU, both in_pixel outputs and the local coordinates are 0.
- Compose (stage 2):
  - No window hit: pixel = 4'd8.
  - Hit window: take that window's ROM pixel. If the window is the selected one, the ROM pixel is ≠ 4'd8 and blink=1, output HILITE; otherwise output the ROM pixel unchanged.
- Blink:
  - A frame tick is hc==0 && vc==0.
  - blink_cnt counts frame ticks from 0 to BLINK_FRAMES−1, then wraps to 0 and toggles blink.
  - blink_cnt is cleared and blink is set to 1 whenever sel changes, so the new selection is visible at once.
  - The blink logic runs in every state.

## Timing
- Reset values: state=MENU, sel=0, blink=1, blink_cnt=0, edge registers=0.
- Output reset values: pixel=4'd8, play_in_pixel=0, exit_in_pixel=0, lbl_hc=0, lbl_vc=0, start_game=0, exit_req=0, menu_active=1.
- Latency: in_pixel and lbl_* are valid 1 cycle after hc/vc. pixel is valid 2 cycles after hc/vc. The 2-cycle horizontal offset is compensated downstream.
- Control path, from a rising edge on btn_sel sampled at cycle n:
  - cycle n+1: edge registered; FSM enters LAUNCH.
  - cycle n+2: start_game or exit_req is high for exactly one cycle.
  - menu_active falls at n+3 on a launch into GAME.
- game_over sampled at cycle n in GAME: menu_active=1 from n+1.
- A button held high produces exactly one edge.
- Reset has priority over every event and takes effect on the next edge, mid-frame or mid-LAUNCH. No pulse may be emitted in the cycle after RST.

## Test plan
- Reset, then scan hc=250, vc=210 with play_pixel=4'd3, blink=1, sel=0 -> pixel=HILITE(15) two cycles later; play_in_pixel=1, lbl_hc=10, lbl_vc=10.
- Same point with play_pixel=4'd8 -> pixel=8. At hc=250, vc=290 with exit_pixel=4'd5 and sel=0 -> pixel=5, exit_in_pixel=1, lbl_vc=10.
- Press down once, then down again -> sel=1 (saturated). EXIT opaque pixels read 15, PLAY pixels are raw. blink_cnt was cleared on the sel change.
- Press up and down in the same cycle -> sel unchanged. Press sel with sel=0 -> exactly one start_game pulse 2 cycles after the edge, menu_active=0, and pixel stays 8 over both windows.
- In GAME, pulse game_over -> MENU with sel=0. Then select EXIT -> one exit_req pulse, state stays MENU, sel=0.
- Run 60 frame ticks with BLINK_FRAMES=30 -> blink toggles at ticks 30 and 60, and selected opaque pixels alternate between 15 and raw. Assert RST during LAUNCH -> no pulse, and all outputs are at reset values the next cycle.

Source files
------------

// File: rtl/menu_controller.sv
// Title-menu sequencer: decodes the PLAY/EXIT label windows, merges the two
// label ROM streams with a blinking highlight, and runs the launch/exit FSM.
module menu_controller #(
    parameter int          PLAY_X       = 240,
    parameter int          PLAY_Y       = 200,
    parameter int          EXIT_X       = 240,
    parameter int          EXIT_Y       = 280,
    parameter int          LBL_W        = 160,
    parameter int          LBL_H        = 56,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [3:0]  HILITE       = 4'd15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic        game_over,
    input  logic [3:0]  play_pixel,
    input  logic [3:0]  exit_pixel,
    output logic        play_in_pixel,
    output logic        exit_in_pixel,
    output logic [9:0]  lbl_hc,
    output logic [9:0]  lbl_vc,
    output logic [3:0]  pixel,
    output logic        start_game,
    output logic        exit_req,
    output logic        menu_active
);

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        LAUNCH = 2'd1,
        GAME   = 2'd2
    } state_t;

    localparam logic [3:0]  TRANSP  = 4'd8;
    localparam logic [10:0] PX_LO   = 11'(PLAY_X);
    localparam logic [10:0] PX_HI   = 11'(PLAY_X + LBL_W);
    localparam logic [10:0] PY_LO   = 11'(PLAY_Y);
    localparam logic [10:0] PY_HI   = 11'(PLAY_Y + LBL_H);
    localparam logic [10:0] EX_LO   = 11'(EXIT_X);
    localparam logic [10:0] EX_HI   = 11'(EXIT_X + LBL_W);
    localparam logic [10:0] EY_LO   = 11'(EXIT_Y);
    localparam logic [10:0] EY_HI   = 11'(EXIT_Y + LBL_H);
    localparam logic [9:0]  PX_OFF  = 10'(PLAY_X);
    localparam logic [9:0]  PY_OFF  = 10'(PLAY_Y);
    localparam logic [9:0]  EX_OFF  = 10'(EXIT_X);
    localparam logic [9:0]  EY_OFF  = 10'(EXIT_Y);
    localparam int          CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Half-open interval test widened to 11 bits so edge+size cannot wrap.
    function automatic logic in_range(input logic [10:0] pos,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic           sel_r;
    logic           sel_nxt_s;
    logic           up_prev_r;
    logic           down_prev_r;
    logic           sel_prev_r;
    logic           blink_r;
    logic [CW-1:0]  blink_cnt_r;

    logic           up_edge_s;
    logic           down_edge_s;
    logic           sel_edge_s;
    logic           frame_tick_s;
    logic           sel_change_s;
    logic [10:0]    hc_w_s;
    logic [10:0]    vc_w_s;
    logic           in_play_s;
    logic           in_exit_s;
    logic           play_hit_s;
    logic           exit_hit_s;
    logic [9:0]     loc_hc_s;
    logic [9:0]     loc_vc_s;
    logic [3:0]     compose_s;

    assign up_edge_s    = btn_up   & ~up_prev_r;
    assign down_edge_s  = btn_down & ~down_prev_r;
    assign sel_edge_s   = btn_sel  & ~sel_prev_r;
    assign frame_tick_s = (hc == 10'd0) && (vc == 10'd0);
    assign sel_change_s = (sel_nxt_s != sel_r);
    assign hc_w_s       = {1'b0, hc};
    assign vc_w_s       = {1'b0, vc};
    assign in_play_s    = in_range(hc_w_s, PX_LO, PX_HI) && in_range(vc_w_s, PY_LO, PY_HI);
    assign in_exit_s    = in_range(hc_w_s, EX_LO, EX_HI) && in_range(vc_w_s, EY_LO, EY_HI);

    // Button history, FSM state and selection registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            up_prev_r   <= 1'b0;
            down_prev_r <= 1'b0;
            sel_prev_r  <= 1'b0;
            state_r     <= MENU;
            sel_r       <= 1'b0;
        end else begin
            up_prev_r   <= btn_up;
            down_prev_r <= btn_down;
            sel_prev_r  <= btn_sel;
            state_r     <= state_nxt_s;
            sel_r       <= sel_nxt_s;
        end
    end

    // Next-state and selection logic; select beats a simultaneous up/down.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        case (state_r)
            MENU: begin
                if (sel_edge_s) begin
                    state_nxt_s = LAUNCH;
                end else if (up_edge_s && !down_edge_s) begin
                    sel_nxt_s = 1'b0;
                end else if (down_edge_s && !up_edge_s) begin
                    sel_nxt_s = 1'b1;
                end else begin
                    sel_nxt_s = sel_r;
                end
            end
            LAUNCH: begin
                if (sel_r) begin
                    state_nxt_s = MENU;
                    sel_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = GAME;
                end
            end
            GAME: begin
                if (game_over) begin
                    state_nxt_s = MENU;
                    sel_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = GAME;
                end
            end
            default: begin
                state_nxt_s = MENU;
                sel_nxt_s   = 1'b0;
            end
        endcase
    end

    // Control pulses and menu visibility, registered off the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_game  <= 1'b0;
            exit_req    <= 1'b0;
            menu_active <= 1'b1;
        end else begin
            start_game  <= (state_r == LAUNCH) && !sel_r;
            exit_req    <= (state_r == LAUNCH) &&  sel_r;
            menu_active <= !((state_r == GAME) && !game_over);
        end
    end

    // Blink timer; a selection change restarts it with the highlight on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_r     <= 1'b1;
            blink_cnt_r <= '0;
        end else if (sel_change_s) begin
            blink_r     <= 1'b1;
            blink_cnt_r <= '0;
        end else if (frame_tick_s) begin
            if (blink_cnt_r == CNT_MAX) begin
                blink_cnt_r <= '0;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + CNT_ONE;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Stage-1 window decode; PLAY wins on overlap, nothing hits outside MENU.
    always_comb begin
        play_hit_s = (state_r == MENU) && in_play_s;
        exit_hit_s = (state_r == MENU) && in_exit_s && !in_play_s;
        loc_hc_s   = 10'd0;
        loc_vc_s   = 10'd0;
        if (play_hit_s) begin
            loc_hc_s = hc - PX_OFF;
            loc_vc_s = vc - PY_OFF;
        end else if (exit_hit_s) begin
            loc_hc_s = hc - EX_OFF;
            loc_vc_s = vc - EY_OFF;
        end else begin
            loc_hc_s = 10'd0;
            loc_vc_s = 10'd0;
        end
    end

    // Stage-1 registers feeding the label ROMs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            play_in_pixel <= 1'b0;
            exit_in_pixel <= 1'b0;
            lbl_hc        <= 10'd0;
            lbl_vc        <= 10'd0;
        end else begin
            play_in_pixel <= play_hit_s;
            exit_in_pixel <= exit_hit_s;
            lbl_hc        <= loc_hc_s;
            lbl_vc        <= loc_vc_s;
        end
    end

    // Stage-2 merge of ROM outputs with highlight substitution.
    always_comb begin
        compose_s = TRANSP;
        if (play_in_pixel) begin
            if (!sel_r && blink_r && (play_pixel != TRANSP)) begin
                compose_s = HILITE;
            end else begin
                compose_s = play_pixel;
            end
        end else if (exit_in_pixel) begin
            if (sel_r && blink_r && (exit_pixel != TRANSP)) begin
                compose_s = HILITE;
            end else begin
                compose_s = exit_pixel;
            end
        end else begin
            compose_s = TRANSP;
        end
    end

    // Stage-2 output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pixel <= TRANSP;
        end else begin
            pixel <= compose_s;
        end
    end

endmodule

// File: tb/tb_menu_controller.sv
// Directed self-checking bench for menu_controller: window decode, compose,
// selection FSM, blink timer and reset behaviour.
module tb_menu_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  hc, vc;
    logic        btn_up, btn_down, btn_sel, game_over;
    logic [3:0]  play_pixel, exit_pixel;
    logic        play_in_pixel, exit_in_pixel;
    logic [9:0]  lbl_hc, lbl_vc;
    logic [3:0]  pixel;
    logic        start_game, exit_req, menu_active;

    int total  = 0;
    int passed = 0;

    menu_controller dut (
        .CLK(CLK), .RST(RST), .hc(hc), .vc(vc),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .game_over(game_over), .play_pixel(play_pixel), .exit_pixel(exit_pixel),
        .play_in_pixel(play_in_pixel), .exit_in_pixel(exit_in_pixel),
        .lbl_hc(lbl_hc), .lbl_vc(lbl_vc), .pixel(pixel),
        .start_game(start_game), .exit_req(exit_req), .menu_active(menu_active)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_play();
        hc = 10'd250; vc = 10'd210;
    endtask

    task automatic at_exit();
        hc = 10'd250; vc = 10'd290;
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        btn_up = u; btn_down = d; btn_sel = s;
        step();
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        hc = 10'd0; vc = 10'd0;
        repeat (n) step();
        at_play();
    endtask

    task automatic test_reset();
        RST = 1'b1; at_play(); play_pixel = 4'd3; exit_pixel = 4'd5;
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; game_over = 1'b0;
        step(); step();
        total++; if (pixel !== 4'd8) $display("FAIL rst_pixel: got %0d want 8", pixel); else passed++;
        total++; if (play_in_pixel !== 1'b0) $display("FAIL rst_play_in: got %b want 0", play_in_pixel); else passed++;
        total++; if (exit_in_pixel !== 1'b0) $display("FAIL rst_exit_in: got %b want 0", exit_in_pixel); else passed++;
        total++; if (lbl_hc !== 10'd0 || lbl_vc !== 10'd0) $display("FAIL rst_lbl: got %0d,%0d want 0,0", lbl_hc, lbl_vc); else passed++;
        total++; if (start_game !== 1'b0 || exit_req !== 1'b0) $display("FAIL rst_pulses: got %b%b want 00", start_game, exit_req); else passed++;
        total++; if (menu_active !== 1'b1) $display("FAIL rst_menu_active: got %b want 1", menu_active); else passed++;
        RST = 1'b0;
    endtask

    task automatic test_play_window();
        at_play(); play_pixel = 4'd3;
        step();
        total++; if (play_in_pixel !== 1'b1 || exit_in_pixel !== 1'b0) $display("FAIL play_hit: got %b%b want 10", play_in_pixel, exit_in_pixel); else passed++;
        total++; if (lbl_hc !== 10'd10 || lbl_vc !== 10'd10) $display("FAIL play_lbl: got %0d,%0d want 10,10", lbl_hc, lbl_vc); else passed++;
        step();
        total++; if (pixel !== 4'd15) $display("FAIL play_hilite: got %0d want 15", pixel); else passed++;
        play_pixel = 4'd8;
        step(); step();
        total++; if (pixel !== 4'd8) $display("FAIL play_transp: got %0d want 8", pixel); else passed++;
        play_pixel = 4'd3;
    endtask

    task automatic test_boundaries();
        hc = 10'd399; vc = 10'd255; step();
        total++; if (play_in_pixel !== 1'b1 || lbl_hc !== 10'd159 || lbl_vc !== 10'd55) $display("FAIL bnd_far_corner: got %b %0d,%0d want 1 159,55", play_in_pixel, lbl_hc, lbl_vc); else passed++;
        hc = 10'd400; vc = 10'd210; step();
        total++; if (play_in_pixel !== 1'b0 || lbl_hc !== 10'd0) $display("FAIL bnd_right_out: got %b %0d want 0 0", play_in_pixel, lbl_hc); else passed++;
        hc = 10'd240; vc = 10'd256; step();
        total++; if (play_in_pixel !== 1'b0 || exit_in_pixel !== 1'b0) $display("FAIL bnd_bottom_out: got %b%b want 00", play_in_pixel, exit_in_pixel); else passed++;
        hc = 10'd239; vc = 10'd200; step();
        total++; if (play_in_pixel !== 1'b0) $display("FAIL bnd_left_out: got %b want 0", play_in_pixel); else passed++;
        step();
        total++; if (pixel !== 4'd8) $display("FAIL bnd_out_pixel: got %0d want 8", pixel); else passed++;
        hc = 10'd240; vc = 10'd200; step();
        total++; if (play_in_pixel !== 1'b1 || lbl_hc !== 10'd0 || lbl_vc !== 10'd0) $display("FAIL bnd_origin: got %b %0d,%0d want 1 0,0", play_in_pixel, lbl_hc, lbl_vc); else passed++;
    endtask

    task automatic test_exit_window();
        at_exit(); exit_pixel = 4'd5; step();
        total++; if (exit_in_pixel !== 1'b1 || play_in_pixel !== 1'b0) $display("FAIL exit_hit: got %b%b want 10", exit_in_pixel, play_in_pixel); else passed++;
        total++; if (lbl_vc !== 10'd10 || lbl_hc !== 10'd10) $display("FAIL exit_lbl: got %0d,%0d want 10,10", lbl_hc, lbl_vc); else passed++;
        step();
        total++; if (pixel !== 4'd5) $display("FAIL exit_raw: got %0d want 5", pixel); else passed++;
    endtask

    task automatic test_navigation();
        at_exit();
        press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0);
        step();
        total++; if (pixel !== 4'd15) $display("FAIL nav_exit_hilite: got %0d want 15", pixel); else passed++;
        at_play(); step(); step();
        total++; if (pixel !== 4'd3) $display("FAIL nav_play_raw: got %0d want 3", pixel); else passed++;
        press(1'b1, 1'b1, 1'b0); step();
        total++; if (pixel !== 4'd3) $display("FAIL nav_updown_ignored: got %0d want 3", pixel); else passed++;
        press(1'b1, 1'b0, 1'b0); step();
        total++; if (pixel !== 4'd15) $display("FAIL nav_up_play: got %0d want 15", pixel); else passed++;
    endtask

    task automatic test_launch_game();
        at_play(); btn_sel = 1'b1; step();
        total++; if (start_game !== 1'b0) $display("FAIL launch_early: got %b want 0", start_game); else passed++;
        step();
        total++; if (start_game !== 1'b1 || exit_req !== 1'b0) $display("FAIL launch_pulse: got %b%b want 10", start_game, exit_req); else passed++;
        total++; if (menu_active !== 1'b1) $display("FAIL launch_active_hold: got %b want 1", menu_active); else passed++;
        btn_sel = 1'b0; step();
        total++; if (start_game !== 1'b0) $display("FAIL launch_one_cycle: got %b want 0", start_game); else passed++;
        total++; if (menu_active !== 1'b0) $display("FAIL launch_active_fall: got %b want 0", menu_active); else passed++;
        step();
        total++; if (pixel !== 4'd8 || play_in_pixel !== 1'b0) $display("FAIL game_play_hidden: got %0d %b want 8 0", pixel, play_in_pixel); else passed++;
        at_exit(); press(1'b0, 1'b1, 1'b1); step();
        total++; if (pixel !== 4'd8 || exit_in_pixel !== 1'b0 || start_game !== 1'b0) $display("FAIL game_exit_hidden: got %0d %b %b want 8 0 0", pixel, exit_in_pixel, start_game); else passed++;
        game_over = 1'b1; step(); game_over = 1'b0;
        total++; if (menu_active !== 1'b1) $display("FAIL game_over_active: got %b want 1", menu_active); else passed++;
        at_play(); step(); step();
        total++; if (pixel !== 4'd15) $display("FAIL game_over_sel0: got %0d want 15", pixel); else passed++;
    endtask

    task automatic test_exit_request();
        int extra;
        at_play(); press(1'b0, 1'b1, 1'b0);
        btn_sel = 1'b1; step();
        total++; if (exit_req !== 1'b0) $display("FAIL exitreq_early: got %b want 0", exit_req); else passed++;
        step();
        total++; if (exit_req !== 1'b1 || start_game !== 1'b0) $display("FAIL exitreq_pulse: got %b%b want 10", exit_req, start_game); else passed++;
        step();
        total++; if (exit_req !== 1'b0 || menu_active !== 1'b1) $display("FAIL exitreq_after: got %b %b want 0 1", exit_req, menu_active); else passed++;
        extra = 0;
        repeat (6) begin
            step();
            if (start_game || exit_req) extra++;
        end
        total++; if (extra !== 0) $display("FAIL held_sel_pulses: got %0d want 0", extra); else passed++;
        btn_sel = 1'b0; step(); step();
        total++; if (pixel !== 4'd15) $display("FAIL exitreq_sel0: got %0d want 15", pixel); else passed++;
    endtask

    task automatic test_blink();
        ticks(29); step(); step();
        total++; if (pixel !== 4'd15) $display("FAIL blink_tick29: got %0d want 15", pixel); else passed++;
        ticks(1); step(); step();
        total++; if (pixel !== 4'd3) $display("FAIL blink_tick30: got %0d want 3", pixel); else passed++;
        ticks(29); step(); step();
        total++; if (pixel !== 4'd3) $display("FAIL blink_tick59: got %0d want 3", pixel); else passed++;
        ticks(1); step(); step();
        total++; if (pixel !== 4'd15) $display("FAIL blink_tick60: got %0d want 15", pixel); else passed++;
        ticks(10); press(1'b0, 1'b1, 1'b0); ticks(25);
        at_exit(); step(); step();
        total++; if (pixel !== 4'd15) $display("FAIL blink_cnt_cleared: got %0d want 15", pixel); else passed++;
        at_play(); step(); step();
        total++; if (pixel !== 4'd3) $display("FAIL blink_unsel_raw: got %0d want 3", pixel); else passed++;
    endtask

    task automatic test_reset_in_launch();
        at_play(); btn_sel = 1'b1; step();
        RST = 1'b1; btn_sel = 1'b0; step();
        total++; if (exit_req !== 1'b0 || start_game !== 1'b0) $display("FAIL rl_pulses: got %b%b want 00", exit_req, start_game); else passed++;
        total++; if (pixel !== 4'd8 || play_in_pixel !== 1'b0 || lbl_hc !== 10'd0 || menu_active !== 1'b1) $display("FAIL rl_outputs: got %0d %b %0d %b want 8 0 0 1", pixel, play_in_pixel, lbl_hc, menu_active); else passed++;
        RST = 1'b0; step();
        total++; if (exit_req !== 1'b0 || start_game !== 1'b0) $display("FAIL rl_after: got %b%b want 00", exit_req, start_game); else passed++;
        step();
        total++; if (pixel !== 4'd15) $display("FAIL rl_sel0: got %0d want 15", pixel); else passed++;
    endtask

    initial begin
        test_reset();
        test_play_window();
        test_boundaries();
        test_exit_window();
        test_navigation();
        test_launch_game();
        test_exit_request();
        test_blink();
        test_reset_in_launch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
